sa_mult_seq: RTL and testbench

- Parametrised sequential shift-and-add multiplier; the next generation of the team's fixed 8-bit shift-add unit.
- Adds generic WIDTH, a second operand, a square/multiply mode select, a start/busy/done handshake, and a held full-width result.
- Sits as a datapath slave under a controller FSM. The controller pulses start and waits for done.

---
 rtl/sa_mult_seq.sv | 108 ++++++++++
 tb/tb_sa_mult_seq.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/sa_mult_seq.sv
// Sequential shift-and-add multiplier (unsigned) with a square/multiply mode select.
// It takes one multiplier bit per cycle and holds the last completed product on q.
module sa_mult_seq #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] q,
  output logic               busy,
  output logic               done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_r;
  logic [2*WIDTH-1:0]   acc_r;
  logic [2*WIDTH-1:0]   q_r;
  logic [WIDTH-1:0]     a_r;
  logic [WIDTH-1:0]     b_r;
  logic [CW-1:0]        cnt_r;
  logic                 busy_r;
  logic                 done_r;
  logic [2*WIDTH-1:0]   addend_s;
  logic [2*WIDTH-1:0]   sum_s;

  // Partial product for the current multiplier bit, and the running sum including it.
  always_comb begin
    addend_s = {(2*WIDTH){1'b0}};
    if (b_r[0]) begin
      addend_s = {{WIDTH{1'b0}}, a_r} << cnt_r;
    end else begin
      addend_s = {(2*WIDTH){1'b0}};
    end
    sum_s = acc_r + addend_s;
  end

  // Control FSM and datapath registers; the last RUN edge writes the sum straight into q.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
      acc_r   <= {(2*WIDTH){1'b0}};
      q_r     <= {(2*WIDTH){1'b0}};
      a_r     <= {WIDTH{1'b0}};
      b_r     <= {WIDTH{1'b0}};
      cnt_r   <= {CW{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            a_r     <= a;
            b_r     <= mode ? a : b;
            acc_r   <= {(2*WIDTH){1'b0}};
            cnt_r   <= {CW{1'b0}};
            busy_r  <= 1'b1;
            state_r <= RUN;
          end else begin
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end
        end
        RUN: begin
          acc_r <= sum_s;
          b_r   <= b_r >> 1;
          cnt_r <= cnt_r + CW'(1);
          if (cnt_r == LAST_CNT) begin
            q_r     <= sum_s;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            state_r <= DONE;
          end else begin
            busy_r  <= 1'b1;
            done_r  <= 1'b0;
            state_r <= RUN;
          end
        end
        DONE: begin
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign q    = q_r;
  assign busy = busy_r;
  assign done = done_r;

endmodule

// File: tb/tb_sa_mult_seq.sv
// Directed bench for sa_mult_seq at WIDTH=8 and WIDTH=4; expected products are hand-computed.
module tb_sa_mult_seq;

  logic        clk;
  logic        reset8, start8, mode8;
  logic [7:0]  a8, b8;
  logic [15:0] q8;
  logic        busy8, done8;
  logic        reset4, start4, mode4;
  logic [3:0]  a4, b4;
  logic [7:0]  q4;
  logic        busy4, done4;

  int checks = 0;
  int errors = 0;

  sa_mult_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset8), .start(start8), .mode(mode8),
    .a(a8), .b(b8), .q(q8), .busy(busy8), .done(done8)
  );

  sa_mult_seq #(.WIDTH(4)) dut4 (
    .clk(clk), .reset(reset4), .start(start4), .mode(mode4),
    .a(a4), .b(b4), .q(q4), .busy(busy4), .done(done4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input int w, input logic st, input logic md,
                       input logic [7:0] av, input logic [7:0] bv);
    if (w == 8) begin
      start8 = st; mode8 = md; a8 = av; b8 = bv;
    end else begin
      start4 = st; mode4 = md; a4 = av[3:0]; b4 = bv[3:0];
    end
  endtask

  function automatic logic [15:0] get_q(input int w);
    return (w == 8) ? q8 : {8'd0, q4};
  endfunction

  function automatic logic get_busy(input int w);
    return (w == 8) ? busy8 : busy4;
  endfunction

  function automatic logic get_done(input int w);
    return (w == 8) ? done8 : done4;
  endfunction

  // disturb: 0 = quiet, 1 = stray start during RUN/DONE, 2 = operands change every cycle
  task automatic run_op(input int w, input logic [7:0] av, input logic [7:0] bv,
                        input logic md, input logic [15:0] expq,
                        input int disturb, input string tag);
    drive(w, 1'b1, md, av, bv);
    @(negedge clk);
    drive(w, 1'b0, md, av, bv);
    for (int i = 0; i < w; i++) begin
      chk({tag, " busy"}, {31'd0, get_busy(w)}, 32'd1);
      chk({tag, " done_low"}, {31'd0, get_done(w)}, 32'd0);
      if (disturb == 1 && i == 1) drive(w, 1'b1, 1'b1, 8'd3, 8'd3);
      if (disturb == 2) drive(w, 1'b0, 1'($urandom_range(0, 1)),
                              8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      @(negedge clk);
    end
    chk({tag, " q"}, {16'd0, get_q(w)}, {16'd0, expq});
    chk({tag, " done"}, {31'd0, get_done(w)}, 32'd1);
    chk({tag, " busy_in_done"}, {31'd0, get_busy(w)}, 32'd0);
    @(negedge clk);
    chk({tag, " done_one_cycle"}, {31'd0, get_done(w)}, 32'd0);
    chk({tag, " idle_busy"}, {31'd0, get_busy(w)}, 32'd0);
    chk({tag, " q_hold"}, {16'd0, get_q(w)}, {16'd0, expq});
    if (disturb != 0) drive(w, 1'b0, 1'b0, 8'd0, 8'd0);
  endtask

  initial begin
    reset8 = 1'b0; reset4 = 1'b0;
    drive(8, 1'b0, 1'b0, 8'd0, 8'd0);
    drive(4, 1'b0, 1'b0, 8'd0, 8'd0);
    @(negedge clk);
    chk("rst q8", {16'd0, q8}, 32'd0);
    chk("rst busy8", {31'd0, busy8}, 32'd0);
    chk("rst done8", {31'd0, done8}, 32'd0);
    chk("rst q4", {24'd0, q4}, 32'd0);
    repeat (7) @(negedge clk);
    reset8 = 1'b1; reset4 = 1'b1;

    // Square, b deliberately zero to show it is ignored
    run_op(8, 8'd12, 8'd0, 1'b1, 16'd144, 0, "sq12");
    repeat (3) @(negedge clk);
    chk("sq12 q_later", {16'd0, q8}, 32'd144);

    run_op(8, 8'd255, 8'd255, 1'b0, 16'd65025, 0, "mul255");
    run_op(8, 8'd13, 8'd0, 1'b0, 16'd0, 0, "b_zero");
    run_op(8, 8'd0, 8'd77, 1'b0, 16'd0, 0, "a_zero");

    run_op(8, 8'd7, 8'd9, 1'b0, 16'd63, 1, "ignored_start");
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("ignored no_done", {31'd0, done8}, 32'd0);
      chk("ignored no_busy", {31'd0, busy8}, 32'd0);
    end
    chk("ignored q", {16'd0, q8}, 32'd63);

    run_op(8, 8'd10, 8'd20, 1'b0, 16'd200, 2, "isolation");

    // Reset in the middle of an operation
    drive(8, 1'b1, 1'b0, 8'd200, 8'd100);
    @(negedge clk);
    drive(8, 1'b0, 1'b0, 8'd200, 8'd100);
    for (int i = 0; i < 3; i++) begin
      chk("midrst busy", {31'd0, busy8}, 32'd1);
      @(negedge clk);
    end
    reset8 = 1'b0;
    #1;
    chk("midrst q", {16'd0, q8}, 32'd0);
    chk("midrst busy_low", {31'd0, busy8}, 32'd0);
    chk("midrst done_low", {31'd0, done8}, 32'd0);
    @(negedge clk);
    reset8 = 1'b1;
    run_op(8, 8'd5, 8'd6, 1'b0, 16'd30, 0, "post_reset");

    // WIDTH=4: square then back-to-back multiply in the first IDLE cycle
    run_op(4, 8'd15, 8'd0, 1'b1, 16'd225, 0, "w4_square");
    run_op(4, 8'd3, 8'd5, 1'b0, 16'd15, 0, "w4_back2back");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
